reg_file_16x8: RTL and testbench

- 16-entry x 8-bit general-purpose register file for the 8-bit CPU datapath.
- Two asynchronous read ports supply ALU operands (RD1, RD2).
- One synchronous write port stores the ALU result.
- Register 15 doubles as the CPU output register and is driven continuously on cpu_out.

---
 rtl/reg_file_16x8_if.sv | 26 ++
 rtl/reg_file_16x8.sv | 39 +++
 tb/tb_reg_file_16x8.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/reg_file_16x8_if.sv
// Register-file access bus: two combinational read ports, one write port, CPU output tap.
interface reg_file_16x8_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    logic [ADDR_W-1:0] RA1;
    logic [ADDR_W-1:0] RA2;
    logic [ADDR_W-1:0] WA;
    logic [DATA_W-1:0] ALUResult;
    logic              write_enable;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;
    logic [DATA_W-1:0] cpu_out;

    // Datapath side: presents addresses and write data, consumes operands.
    modport master (
        output RA1, RA2, WA, ALUResult, write_enable,
        input  RD1, RD2, cpu_out
    );

    // Register file side.
    modport slave (
        input  RA1, RA2, WA, ALUResult, write_enable,
        output RD1, RD2, cpu_out
    );
endinterface

// File: rtl/reg_file_16x8.sv
// 16 x 8 general-purpose register file: two async read ports, one sync write port,
// and the output register mirrored continuously on cpu_out.
module reg_file_16x8 #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned OUT_REG = 15
) (
    input  logic            CLK,
    input  logic            RST,
    reg_file_16x8_if.slave  bus
);
    localparam int unsigned NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] OUT_IDX = ADDR_W'(OUT_REG);

    logic [DATA_W-1:0] mem_q [NREGS];
    logic [DATA_W-1:0] mem_d [NREGS];

    // Next-state storage: only the addressed register changes on a strobed write.
    always_comb begin
        mem_d = mem_q;
        if (bus.write_enable) begin
            mem_d[bus.WA] = bus.ALUResult;
        end
    end

    // Storage update; reset clears everything at once and blocks the write.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Reads come straight from storage, so a same-address write shows only after the edge.
    assign bus.RD1     = mem_q[bus.RA1];
    assign bus.RD2     = mem_q[bus.RA2];
    assign bus.cpu_out = mem_q[OUT_IDX];
endmodule

// File: tb/tb_reg_file_16x8.sv
// Directed self-checking bench for reg_file_16x8.
module tb_reg_file_16x8;
    logic CLK;
    logic RST;
    int   tests_run;
    int   tests_failed;

    reg_file_16x8_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    reg_file_16x8 #(.DATA_W(8), .ADDR_W(4), .OUT_REG(15)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37 + 5) & 255);
    endfunction

    // Present one write in the low phase, let the next rising edge take it.
    task automatic do_write(input logic [3:0] wa, input logic [7:0] d);
        @(negedge CLK);
        bus.WA           = wa;
        bus.ALUResult    = d;
        bus.write_enable = 1'b1;
        @(posedge CLK);
        #1;
        bus.write_enable = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.RA1 = 4'd1;
        bus.RA2 = 4'd2;
        bus.WA = 4'd0;
        bus.ALUResult = 8'h00;
        bus.write_enable = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        tests_run++; if (bus.RD1 !== 8'h00) begin tests_failed++; $display("FAIL reset_hold_rd1: got %h expected 00", bus.RD1); end
        tests_run++; if (bus.RD2 !== 8'h00) begin tests_failed++; $display("FAIL reset_hold_rd2: got %h expected 00", bus.RD2); end
        tests_run++; if (bus.cpu_out !== 8'h00) begin tests_failed++; $display("FAIL reset_hold_cpu_out: got %h expected 00", bus.cpu_out); end
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        tests_run++; if (bus.RD1 !== 8'h00) begin tests_failed++; $display("FAIL reset_rel_rd1: got %h expected 00", bus.RD1); end
        tests_run++; if (bus.RD2 !== 8'h00) begin tests_failed++; $display("FAIL reset_rel_rd2: got %h expected 00", bus.RD2); end
        tests_run++; if (bus.cpu_out !== 8'h00) begin tests_failed++; $display("FAIL reset_rel_cpu_out: got %h expected 00", bus.cpu_out); end
    endtask

    task automatic test_basic_write();
        do_write(4'd10, 8'h03);
        bus.RA1 = 4'd10;
        bus.RA2 = 4'd2;
        #1;
        tests_run++; if (bus.RD1 !== 8'h03) begin tests_failed++; $display("FAIL basic_rd1: got %h expected 03", bus.RD1); end
        tests_run++; if (bus.RD2 !== 8'h00) begin tests_failed++; $display("FAIL basic_rd2: got %h expected 00", bus.RD2); end
        tests_run++; if (bus.cpu_out !== 8'h00) begin tests_failed++; $display("FAIL basic_cpu_out: got %h expected 00", bus.cpu_out); end
    endtask

    task automatic test_write_disabled();
        @(negedge CLK);
        bus.write_enable = 1'b0;
        bus.WA = 4'd2;
        bus.ALUResult = 8'hAA;
        @(posedge CLK);
        #1;
        bus.RA2 = 4'd2;
        bus.RA1 = 4'd10;
        #1;
        tests_run++; if (bus.RD2 !== 8'h00) begin tests_failed++; $display("FAIL wdis_rd2: got %h expected 00", bus.RD2); end
        tests_run++; if (bus.RD1 !== 8'h03) begin tests_failed++; $display("FAIL wdis_rd1: got %h expected 03", bus.RD1); end
    endtask

    task automatic test_output_reg();
        do_write(4'd15, 8'h55);
        tests_run++; if (bus.cpu_out !== 8'h55) begin tests_failed++; $display("FAIL outreg_cpu_out: got %h expected 55", bus.cpu_out); end
        bus.RA1 = 4'd15;
        bus.RA2 = 4'd0;
        #1;
        tests_run++; if (bus.RD1 !== 8'h55) begin tests_failed++; $display("FAIL outreg_rd1: got %h expected 55", bus.RD1); end
        tests_run++; if (bus.RD2 !== 8'h00) begin tests_failed++; $display("FAIL outreg_rd2: got %h expected 00", bus.RD2); end
    endtask

    task automatic test_rw_same_addr();
        do_write(4'd3, 8'h11);
        @(negedge CLK);
        bus.RA1 = 4'd3;
        bus.WA = 4'd3;
        bus.ALUResult = 8'h22;
        bus.write_enable = 1'b1;
        #1;
        tests_run++; if (bus.RD1 !== 8'h11) begin tests_failed++; $display("FAIL rw_before_edge: got %h expected 11", bus.RD1); end
        @(posedge CLK);
        #1;
        bus.write_enable = 1'b0;
        tests_run++; if (bus.RD1 !== 8'h22) begin tests_failed++; $display("FAIL rw_after_edge: got %h expected 22", bus.RD1); end
        // Strobe pulsed and released entirely between edges must not store anything.
        @(negedge CLK);
        bus.ALUResult = 8'hEE;
        bus.write_enable = 1'b1;
        #2;
        bus.write_enable = 1'b0;
        @(posedge CLK);
        #1;
        tests_run++; if (bus.RD1 !== 8'h22) begin tests_failed++; $display("FAIL midcycle_glitch: got %h expected 22", bus.RD1); end
    endtask

    task automatic test_same_port_addr();
        bus.RA1 = 4'd10;
        bus.RA2 = 4'd10;
        #1;
        tests_run++; if (bus.RD1 !== 8'h03) begin tests_failed++; $display("FAIL same_addr_rd1: got %h expected 03", bus.RD1); end
        tests_run++; if (bus.RD2 !== 8'h03) begin tests_failed++; $display("FAIL same_addr_rd2: got %h expected 03", bus.RD2); end
    endtask

    task automatic test_reset_mid_op();
        bus.RA1 = 4'd10;
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        tests_run++; if (bus.cpu_out !== 8'h00) begin tests_failed++; $display("FAIL midrst_cpu_out: got %h expected 00", bus.cpu_out); end
        tests_run++; if (bus.RD1 !== 8'h00) begin tests_failed++; $display("FAIL midrst_rd1: got %h expected 00", bus.RD1); end
        bus.WA = 4'd10;
        bus.ALUResult = 8'h99;
        bus.write_enable = 1'b1;
        @(posedge CLK);
        #1;
        tests_run++; if (bus.RD1 !== 8'h00) begin tests_failed++; $display("FAIL midrst_write_blocked: got %h expected 00", bus.RD1); end
        @(negedge CLK);
        bus.write_enable = 1'b0;
        RST = 1'b0;
        #1;
        tests_run++; if (bus.RD1 !== 8'h00) begin tests_failed++; $display("FAIL midrst_after_rel: got %h expected 00", bus.RD1); end
        do_write(4'd10, 8'h44);
        tests_run++; if (bus.RD1 !== 8'h44) begin tests_failed++; $display("FAIL midrst_first_write: got %h expected 44", bus.RD1); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e1;
        logic [7:0] e2;
        for (int i = 0; i < 16; i++) begin
            do_write(4'(i), pat(i));
        end
        for (int i = 0; i < 16; i++) begin
            bus.RA1 = 4'(i);
            bus.RA2 = 4'(15 - i);
            e1 = pat(i);
            e2 = pat(15 - i);
            #1;
            tests_run++; if (bus.RD1 !== e1) begin tests_failed++; $display("FAIL b2b_rd1[%0d]: got %h expected %h", i, bus.RD1, e1); end
            tests_run++; if (bus.RD2 !== e2) begin tests_failed++; $display("FAIL b2b_rd2[%0d]: got %h expected %h", 15 - i, bus.RD2, e2); end
        end
        e1 = pat(15);
        tests_run++; if (bus.cpu_out !== e1) begin tests_failed++; $display("FAIL b2b_cpu_out: got %h expected %h", bus.cpu_out, e1); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_basic_write();
        test_write_disabled();
        test_output_reg();
        test_rw_same_addr();
        test_same_port_addr();
        test_reset_mid_op();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
